// File: rtl/ccsds_turbo_paddr_gen.sv
// CCSDS turbo permutation address generator: emits one interleaved address pi(s)-1
// per enabled clock for s = 1..N (forward) or s = N..1 (backward).
module ccsds_turbo_paddr_gen #(
  parameter int pW = 14
) (
  input  logic            iclk,
  input  logic            ireset,
  input  logic            iclkena,
  input  logic            istart,
  input  logic            idir,
  input  logic [pW-1:0]   iN,
  input  logic [pW-1:0]   iK2,
  input  logic [4*pW-1:0] iP,
  input  logic [4*pW-1:0] iPcomp,
  output logic            obusy,
  output logic            oval,
  output logic [pW-1:0]   oaddr,
  output logic [pW-1:0]   onat,
  output logic            osop,
  output logic            oeop
);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

  localparam logic [pW-1:0] ZERO = pW'(0);
  localparam logic [pW-1:0] ONE  = pW'(1);
  localparam logic [pW-1:0] C21  = pW'(21);

  state_t            state_q, state_d;
  logic [1:0]        i_q, i_d;
  logic [pW-1:0]     j_q, j_d;
  logic              m_q, m_d;
  logic [pW-1:0]     cb_q, cb_d;
  logic [pW-1:0]     nat_q, nat_d;
  logic              dir_q, dir_d;
  logic              first_q, first_d;
  logic [pW-1:0]     n_q, n_d;
  logic [pW-1:0]     k2_q, k2_d;
  logic [4*pW-1:0]   p_q, p_d;
  logic [4*pW-1:0]   pc_q, pc_d;
  logic              oval_q, oval_d;
  logic              osop_q, osop_d;
  logic              oeop_q, oeop_d;
  logic [pW-1:0]     oaddr_q, oaddr_d;
  logic [pW-1:0]     onat_q, onat_d;

  logic [1:0]        t_s;
  logic [pW-1:0]     c_s;
  logic [pW-1:0]     addr_s;
  logic              last_s;

  // Segment index i maps to prime slot t = (19*i+1) mod 4.
  function automatic logic [1:0] t_of(input logic [1:0] i);
    return {i[1], ~i[0]};
  endfunction

  function automatic logic [pW-1:0] sel(input logic [4*pW-1:0] vec, input logic [1:0] t);
    logic [pW-1:0] r;
    case (t)
      2'd0:    r = vec[0*pW +: pW];
      2'd1:    r = vec[1*pW +: pW];
      2'd2:    r = vec[2*pW +: pW];
      2'd3:    r = vec[3*pW +: pW];
      default: r = ZERO;
    endcase
    return r;
  endfunction

  // Both operands are below k, so one conditional subtract completes the reduction.
  function automatic logic [pW-1:0] mod_add(input logic [pW-1:0] a, input logic [pW-1:0] b,
                                            input logic [pW-1:0] k);
    logic [pW:0] sum;
    logic [pW:0] dif;
    sum = {1'b0, a} + {1'b0, b};
    dif = sum - {1'b0, k};
    if (sum >= {1'b0, k}) begin
      return dif[pW-1:0];
    end else begin
      return sum[pW-1:0];
    end
  endfunction

  // Current address from the walk state: oaddr = 8c + 2t + 1 - m.
  always_comb begin
    t_s    = t_of(i_q);
    c_s    = m_q ? mod_add(cb_q, C21, k2_q) : cb_q;
    addr_s = {c_s[pW-4:0], 3'b000} + {{(pW-3){1'b0}}, t_s, 1'b1} - {{(pW-1){1'b0}}, m_q};
    last_s = dir_q ? (nat_q == ZERO) : (nat_q == (n_q - ONE));
  end

  // Next-state: start latching, then one step of the (i, j, m, cb) walk per beat.
  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    m_d     = m_q;
    cb_d    = cb_q;
    nat_d   = nat_q;
    dir_d   = dir_q;
    first_d = first_q;
    n_d     = n_q;
    k2_d    = k2_q;
    p_d     = p_q;
    pc_d    = pc_q;
    oval_d  = 1'b0;
    osop_d  = 1'b0;
    oeop_d  = 1'b0;
    oaddr_d = oaddr_q;
    onat_d  = onat_q;
    case (state_q)
      ST_IDLE: begin
        if (istart) begin
          state_d = ST_RUN;
          dir_d   = idir;
          n_d     = iN;
          k2_d    = iK2;
          p_d     = iP;
          pc_d    = iPcomp;
          first_d = 1'b1;
          if (idir) begin
            i_d   = 2'd3;
            j_d   = iK2 - ONE;
            m_d   = 1'b1;
            cb_d  = sel(iPcomp, t_of(2'd3));
            nat_d = iN - ONE;
          end else begin
            i_d   = 2'd0;
            j_d   = ZERO;
            m_d   = 1'b0;
            cb_d  = ZERO;
            nat_d = ZERO;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        oval_d  = 1'b1;
        osop_d  = first_q;
        oeop_d  = last_s;
        oaddr_d = addr_s;
        onat_d  = nat_q;
        first_d = 1'b0;
        if (last_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RUN;
        end
        if (!dir_q) begin
          nat_d = nat_q + ONE;
          if (!m_q) begin
            m_d = 1'b1;
          end else begin
            m_d = 1'b0;
            if (j_q == (k2_q - ONE)) begin
              j_d  = ZERO;
              i_d  = i_q + 2'd1;
              cb_d = ZERO;
            end else begin
              j_d  = j_q + ONE;
              cb_d = mod_add(cb_q, sel(p_q, t_s), k2_q);
            end
          end
        end else begin
          nat_d = nat_q - ONE;
          if (m_q) begin
            m_d = 1'b0;
          end else begin
            m_d = 1'b1;
            if (j_q == ZERO) begin
              j_d  = k2_q - ONE;
              i_d  = i_q - 2'd1;
              cb_d = sel(pc_q, t_of(i_q - 2'd1));
            end else begin
              j_d  = j_q - ONE;
              cb_d = mod_add(cb_q, sel(pc_q, t_s), k2_q);
            end
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; iclkena low freezes everything.
  always_ff @(posedge iclk or negedge ireset) begin
    if (!ireset) begin
      state_q <= ST_IDLE;
      i_q     <= 2'd0;
      j_q     <= ZERO;
      m_q     <= 1'b0;
      cb_q    <= ZERO;
      nat_q   <= ZERO;
      dir_q   <= 1'b0;
      first_q <= 1'b0;
      n_q     <= ZERO;
      k2_q    <= ZERO;
      p_q     <= {(4*pW){1'b0}};
      pc_q    <= {(4*pW){1'b0}};
      oval_q  <= 1'b0;
      osop_q  <= 1'b0;
      oeop_q  <= 1'b0;
      oaddr_q <= ZERO;
      onat_q  <= ZERO;
    end else if (iclkena) begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      m_q     <= m_d;
      cb_q    <= cb_d;
      nat_q   <= nat_d;
      dir_q   <= dir_d;
      first_q <= first_d;
      n_q     <= n_d;
      k2_q    <= k2_d;
      p_q     <= p_d;
      pc_q    <= pc_d;
      oval_q  <= oval_d;
      osop_q  <= osop_d;
      oeop_q  <= oeop_d;
      oaddr_q <= oaddr_d;
      onat_q  <= onat_d;
    end
  end

  assign obusy = (state_q == ST_RUN);
  assign oval  = oval_q;
  assign osop  = osop_q;
  assign oeop  = oeop_q;
  assign oaddr = oaddr_q;
  assign onat  = onat_q;

endmodule

// File: tb/tb_ccsds_turbo_paddr_gen.sv
// Scoreboard bench for ccsds_turbo_paddr_gen: expected beats come from the CCSDS pi(s)
// formula evaluated directly with integer arithmetic.
module tb_ccsds_turbo_paddr_gen;
  localparam int pW = 14;

  logic            iclk = 1'b0;
  logic            ireset, iclkena, istart, idir;
  logic [pW-1:0]   iN, iK2;
  logic [4*pW-1:0] iP, iPcomp;
  logic            obusy, oval, osop, oeop;
  logic [pW-1:0]   oaddr, onat;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [pW-1:0] addr;
    logic [pW-1:0] nat;
    logic          sop;
    logic          eop;
  } beat_t;

  beat_t exp_q[$];
  int    cap_addr[$];
  int    cap_nat[$];
  int    fwd_ref[$];
  int    primes[4] = '{31, 37, 43, 47};
  int    k2_tab[4] = '{223, 446, 892, 1115};

  ccsds_turbo_paddr_gen #(.pW(pW)) dut (
    .iclk(iclk), .ireset(ireset), .iclkena(iclkena), .istart(istart), .idir(idir),
    .iN(iN), .iK2(iK2), .iP(iP), .iPcomp(iPcomp),
    .obusy(obusy), .oval(oval), .oaddr(oaddr), .onat(onat), .osop(osop), .oeop(oeop)
  );

  always #5 iclk = ~iclk;

  function automatic void check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  // Golden model: pi(s)-1 for s = 1..N, queued in emission order.
  task automatic push_frame(input int k2, input bit dir);
    int    n;
    int    pi_a[$];
    beat_t b;
    n = 8 * k2;
    for (int s = 1; s <= n; s++) begin
      int q, m, i, j, t, c;
      q = s - 1;
      m = q % 2;
      i = q / (2 * k2);
      j = q / 2 - i * k2;
      t = (19 * i + 1) % 4;
      c = (primes[t] * j + 21 * m) % k2;
      pi_a.push_back(2 * (t + 4 * c + 1) - m - 1);
    end
    for (int idx = 0; idx < n; idx++) begin
      int k;
      k = dir ? (n - 1 - idx) : idx;
      b.addr = pW'(pi_a[k]);
      b.nat  = pW'(k);
      b.sop  = (idx == 0);
      b.eop  = (idx == n - 1);
      exp_q.push_back(b);
    end
  endtask

  // Monitor: pops one expected beat per oval beat consumed by an enabled edge,
  // and checks that outputs held across a disabled edge.
  logic [2*pW+3:0] snap;
  bit              snap_ok  = 1'b0;
  bit              prev_ena = 1'b1;
  always @(negedge iclk) begin
    logic [2*pW+3:0] cur;
    beat_t           b;
    cur = {obusy, oval, osop, oeop, oaddr, onat};
    if (!ireset) begin
      snap_ok = 1'b0;
    end else begin
      if (snap_ok && !prev_ena) check("hold_while_disabled", longint'(cur), longint'(snap));
      if (oval && iclkena) begin
        if (exp_q.size() == 0) begin
          check("unexpected_oval", 1, 0);
        end else begin
          b = exp_q.pop_front();
          check("oaddr", longint'(oaddr), longint'(b.addr));
          check("onat", longint'(onat), longint'(b.nat));
          check("osop", longint'(osop), longint'(b.sop));
          check("oeop", longint'(oeop), longint'(b.eop));
        end
        cap_addr.push_back(int'(oaddr));
        cap_nat.push_back(int'(onat));
      end
      snap     = cur;
      snap_ok  = 1'b1;
      prev_ena = iclkena;
    end
  end

  task automatic start_frame(input int k2, input bit dir);
    int guard;
    guard   = 0;
    iclkena = 1'b1;
    while (obusy && guard < 40000) begin
      @(posedge iclk); #1;
      guard++;
    end
    if (obusy) check("start_wait_timeout", 1, 0);
    iK2  = pW'(k2);
    iN   = pW'(8 * k2);
    idir = dir;
    for (int t = 0; t < 4; t++) begin
      iP[t*pW +: pW]     = pW'(primes[t]);
      iPcomp[t*pW +: pW] = pW'(k2 - primes[t]);
    end
    cap_addr.delete();
    cap_nat.delete();
    push_frame(k2, dir);
    istart = 1'b1;
    @(posedge iclk); #1;
    istart = 1'b0;
    check("busy_after_start", longint'(obusy), 1);
    check("no_oval_after_start", longint'(oval), 0);
  endtask

  // mode 0: enable held high; 1: random enable; 2: random istart/junk inputs while busy.
  task automatic run_frame(input int mode, input int budget);
    int guard;
    guard = 0;
    while (obusy && guard < budget) begin
      @(posedge iclk); #1;
      guard++;
      iclkena = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
      if (mode == 2 && obusy) begin
        istart = 1'($urandom_range(0, 1));
        idir   = 1'($urandom_range(0, 1));
        iK2    = pW'($urandom_range(30, 2000));
        iN     = pW'($urandom_range(30, 8000));
      end else begin
        istart = 1'b0;
      end
    end
    if (obusy) check("frame_timeout", 1, 0);
    istart  = 1'b0;
    iclkena = 1'b1;
    @(negedge iclk); #1;
    check("missing_beats", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic check_perm(input int n);
    bit seen[];
    int bad;
    seen = new[n];
    bad  = 0;
    foreach (cap_addr[k]) begin
      if (cap_addr[k] < 0 || cap_addr[k] >= n || seen[cap_addr[k]]) bad++;
      else seen[cap_addr[k]] = 1'b1;
    end
    check($sformatf("perm_n%0d", n), bad, 0);
  endtask

  initial begin
    int n, bad, k2r, guard;
    bit dr;
    ireset = 1'b0; iclkena = 1'b0; istart = 1'b0; idir = 1'b0;
    iN = '0; iK2 = '0; iP = '0; iPcomp = '0;
    repeat (3) @(posedge iclk);
    #1;
    check("rst_obusy", longint'(obusy), 0);
    check("rst_oval", longint'(oval), 0);
    check("rst_osop", longint'(osop), 0);
    check("rst_oeop", longint'(oeop), 0);
    check("rst_oaddr", longint'(oaddr), 0);
    check("rst_onat", longint'(onat), 0);
    ireset  = 1'b1;
    iclkena = 1'b1;
    @(posedge iclk); #1;

    // istart while disabled must be ignored.
    iK2 = pW'(223); iN = pW'(1784);
    for (int t = 0; t < 4; t++) begin
      iP[t*pW +: pW]     = pW'(primes[t]);
      iPcomp[t*pW +: pW] = pW'(223 - primes[t]);
    end
    iclkena = 1'b0;
    istart  = 1'b1;
    repeat (3) @(posedge iclk);
    #1;
    check("start_disabled_busy", longint'(obusy), 0);
    istart  = 1'b0;
    iclkena = 1'b1;
    @(posedge iclk); #1;
    check("start_disabled_busy_after", longint'(obusy), 0);
    check("start_disabled_oval", longint'(oval), 0);

    // All K2 values, forward then backward back-to-back.
    for (int k = 0; k < 4; k++) begin
      n = 8 * k2_tab[k];
      start_frame(k2_tab[k], 1'b0);
      run_frame(0, n + 20);
      check($sformatf("fwd_beats_k%0d", k2_tab[k]), cap_addr.size(), n);
      check_perm(n);
      if (k == 0) begin
        check("fwd_a0", cap_addr[0], 3);
        check("fwd_a1", cap_addr[1], 170);
        check("fwd_a2", cap_addr[2], 299);
        check("fwd_a3", cap_addr[3], 466);
        check("fwd_a446", cap_addr[446], 1);
        check("fwd_nat446", cap_nat[446], 446);
        check("fwd_a447", cap_addr[447], 168);
        check("fwd_last", cap_addr[n-1], 1612);
      end
      fwd_ref = cap_addr;
      start_frame(k2_tab[k], 1'b1);
      run_frame(0, n + 20);
      check($sformatf("bwd_beats_k%0d", k2_tab[k]), cap_addr.size(), n);
      check_perm(n);
      bad = 0;
      for (int idx = 0; idx < cap_addr.size() && idx < n; idx++) begin
        if (cap_addr[idx] != fwd_ref[n-1-idx]) bad++;
      end
      check($sformatf("bwd_reverse_k%0d", k2_tab[k]), bad, 0);
      if (k == 0) begin
        check("bwd_a0", cap_addr[0], 1612);
        check("bwd_nat0", cap_nat[0], 1783);
        check("bwd_a1", cap_addr[1], 1445);
        check("bwd_last", cap_addr[n-1], 3);
        check("bwd_last_nat", cap_nat[n-1], 0);
      end
    end
    @(posedge iclk); #1;
    check("idle_oval_after_eop", longint'(oval), 0);
    check("idle_busy_after_eop", longint'(obusy), 0);

    // Random clock enable.
    k2r = ($urandom_range(0, 1) == 0) ? 223 : 446;
    dr  = 1'($urandom_range(0, 1));
    start_frame(k2r, dr);
    run_frame(1, 16 * 8 * k2r + 100);
    check("rand_ena_beats", cap_addr.size(), 8 * k2r);

    // istart and parameter noise during RUN.
    start_frame(223, 1'b0);
    run_frame(2, 1784 + 20);
    check("noise_beats", cap_addr.size(), 1784);
    check_perm(1784);

    // Asynchronous reset mid-frame.
    start_frame(223, 1'b0);
    guard = 0;
    while (cap_addr.size() < 100 && guard < 500) begin
      @(posedge iclk); #1;
      guard++;
    end
    check("reach_beat100", longint'(cap_addr.size() >= 100), 1);
    #2;
    ireset = 1'b0;
    #1;
    check("arst_oval", longint'(oval), 0);
    check("arst_obusy", longint'(obusy), 0);
    check("arst_oaddr", longint'(oaddr), 0);
    check("arst_onat", longint'(onat), 0);
    exp_q.delete();
    repeat (2) @(posedge iclk);
    #1;
    check("arst_held_oval", longint'(oval), 0);
    ireset = 1'b1;
    @(posedge iclk); #1;
    check("post_rst_idle", longint'(oval), 0);
    start_frame(223, 1'b0);
    run_frame(0, 1784 + 20);
    check("restart_a0", cap_addr.size() > 0 ? cap_addr[0] : -1, 3);
    check("restart_beats", cap_addr.size(), 1784);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ccsds_turbo_paddr_gen.md
# ccsds_turbo_paddr_gen

Permutation address generator for the CCSDS turbo codec: it consumes the permutation parameters (N, K2, P[4], Pcomp[4]) produced by the permutation parameter table and emits, one per enabled clock, the 0-based interleaved address π(s)−1 for s = 1..N. It runs in either direction: forward for the encoder and the decoder's forward recursion, backward (s = N..1) for the decoder's backward recursion. It sits between the parameter table and the interleaved-side RAM address ports.

## Interface
- pW, 14, address/parameter width (N ≤ 8·1115 = 8920)
- iclk  in  1  clock, rising edge
- ireset  in  1  asynchronous, active-low reset
- iclkena  in  1  clock enable; low freezes all state and outputs
- istart  in  1  start pulse; sampled only when iclkena=1 and obusy=0
- idir  in  1  0 = forward (s ascending), 1 = backward (s descending); latched on istart
- iN  in  pW  frame length N = 8·K2; latched on istart
- iK2  in  pW  K2 (223·{1,2,4,5}); latched on istart
- iP  in  4×pW  primes {31,37,43,47}, indexed by t; latched on istart
- iPcomp  in  4×pW  K2−iP[t]; latched on istart
- obusy  out  1  generation in progress
- oval  out  1  oaddr/onat valid
- oaddr  out  pW  interleaved address π(s)−1
- onat  out  pW  natural address s−1
- osop  out  1  first address of the frame
- oeop  out  1  last address of the frame

## Operation
- State: segment i (0..3), j (0..K2−1), m (0/1), cb = (P[t]·j) mod K2, natural counter, latched parameters. t = (19·i+1) mod 4, i.e. i=0→t=1, 1→0, 2→3, 3→2.
- Address: c = m ? (cb+21) mod K2 : cb; oaddr = 8·c + 2·t + 1 − m.
- Modular adds are a single conditional subtract (operands < K2, K2 > 21); no multipliers.
- Forward: start i=0, j=0, m=0, cb=0. Each step: m=0→m=1; m=1→m=0, j+1, cb=(cb+P[t]) mod K2. When j wraps from K2−1 to 0, i+1 and cb=0.
- Backward: start i=3, j=K2−1, m=1, cb=Pcomp[t(3)]. Each step: m=1→m=0; m=0→m=1, j−1, cb=(cb+Pcomp[t]) mod K2. When j wraps from 0 to K2−1, i−1 and cb=Pcomp[t(new i)].
- FSM: IDLE → (istart & iclkena) → RUN; RUN → IDLE after the step producing the last address. istart in RUN is ignored.
- onat: 0..N−1 forward, N−1..0 backward.

## Timing
- Reset (async, ireset=0): obusy=0, oval=0, osop=0, oeop=0, oaddr=0, onat=0, FSM=IDLE. Reset mid-frame aborts immediately; no further oval.
- All transitions require iclkena=1; with iclkena=0 every register holds, including oval.
- istart accepted at edge E0 → obusy=1 after E0; first oval=1 with osop=1 after E1 (latency 2 enabled edges).
- N contiguous oval cycles while iclkena=1; oeop accompanies the N-th; obusy drops on the same edge that registers the last address.
- oval=0 after the edge following the oeop beat unless a new frame started; a new istart is accepted the cycle obusy=0, giving back-to-back frames with one idle beat.
- osop and oeop are single-beat qualifiers on oval.

## Test plan
- K2=223, N=1784, forward: first four oaddr = 3, 170, 299, 466; beat 447 (onat=446) = 1, beat 448 = 168; last = 1612 with oeop; oval high exactly 1784 beats.
- Same parameters, backward: first oaddr = 1612 (onat=1783, osop), second = 1445; last = 3 with oeop, onat=0.
- All four K2 values, both directions: collected oaddr set is a permutation of 0..N−1; backward sequence equals the reversed forward sequence; matches a golden model of the CCSDS π(s) formula.
- iclkena toggled randomly during a frame: output sequence identical to the run with iclkena=1, held values unchanged while low.
- istart pulsed during RUN: ignored, frame continues unaltered; istart with iclkena=0: ignored.
- ireset asserted at beat 100: outputs go to reset values asynchronously; a new istart after release restarts at oaddr=3.
